// File: rtl/dmr_retry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmr_retry_ctrl
// Description : Retry/escalation controller for a dual-modular-redundant
//               stream join. Drives the join's repeat input for a fixed
//               back-off window after each mismatch and counts mismatches.
//               It escalates to a sticky fault once MaxRetries consecutive
//               mismatches occur with no successful transfer in between.
// Ports       : clk_i          - clock, rising edge
//               rst_ni         - asynchronous active-low reset
//               error_i        - mismatch flag from the join comparator
//               handshake_i    - join output handshake completed this cycle
//               clear_i        - synchronous clear of fault and counters
//               repeat_o       - repeat request to the join (registered)
//               retry_active_o - high while backing off
//               fault_o        - sticky fault flag
//               retry_cnt_o    - consecutive-mismatch count
//               err_count_o    - total mismatches, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module dmr_retry_ctrl #(
   parameter int MaxRetries    = 3,
   parameter int BackoffCycles = 2,
   parameter int CntWidth      = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              error_i,
   input  logic                              handshake_i,
   input  logic                              clear_i,
   output logic                              repeat_o,
   output logic                              retry_active_o,
   output logic                              fault_o,
   output logic [$clog2(MaxRetries+1)-1:0]   retry_cnt_o,
   output logic [CntWidth-1:0]               err_count_o
);

   localparam int RW = $clog2(MaxRetries + 1);
   // The back-off counter only has to hold BackoffCycles-1.
   localparam int BW = (BackoffCycles > 1) ? $clog2(BackoffCycles) : 1;

   localparam logic [RW-1:0] c_max_retries = RW'(MaxRetries);
   localparam logic [BW-1:0] c_backoff_ld  = BW'(BackoffCycles - 1);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_BACKOFF = 2'd1;
   localparam logic [1:0] ST_FAULT   = 2'd2;

   logic [1:0]          r_state;
   logic [BW-1:0]       r_backoff;
   logic [RW-1:0]       r_retry_cnt;
   logic [CntWidth-1:0] r_err_count;
   logic                r_repeat;
   logic                r_retry_active;
   logic                r_fault;

   logic [RW-1:0]       w_retry_inc;
   logic                w_err_sat;

   // In Run the count never exceeds MaxRetries-1, so the increment cannot wrap.
   assign w_retry_inc = r_retry_cnt + 1'b1;
   assign w_err_sat   = &r_err_count;

   // Output flags are registered alongside the state so every output is a
   // flop with no path back to the inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state        <= ST_RUN;
         r_backoff      <= '0;
         r_retry_cnt    <= '0;
         r_err_count    <= '0;
         r_repeat       <= 1'b0;
         r_retry_active <= 1'b0;
         r_fault        <= 1'b0;
      end else if (clear_i) begin
         r_state        <= ST_RUN;
         r_backoff      <= '0;
         r_retry_cnt    <= '0;
         r_err_count    <= '0;
         r_repeat       <= 1'b0;
         r_retry_active <= 1'b0;
         r_fault        <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (error_i) begin
                  // Error wins over a same-cycle handshake.
                  if (!w_err_sat) begin
                     r_err_count <= r_err_count + 1'b1;
                  end
                  r_retry_cnt <= w_retry_inc;
                  r_repeat    <= 1'b1;
                  if (w_retry_inc == c_max_retries) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state        <= ST_BACKOFF;
                     r_backoff      <= c_backoff_ld;
                     r_retry_active <= 1'b1;
                  end
               end else if (handshake_i) begin
                  r_retry_cnt <= '0;
               end
            end
            ST_BACKOFF: begin
               if (r_backoff == '0) begin
                  r_state        <= ST_RUN;
                  r_repeat       <= 1'b0;
                  r_retry_active <= 1'b0;
               end else begin
                  r_backoff <= r_backoff - 1'b1;
               end
            end
            ST_FAULT: begin
               // Sticky until clear_i.
               r_state <= ST_FAULT;
            end
            default: begin
               r_state        <= ST_RUN;
               r_repeat       <= 1'b0;
               r_retry_active <= 1'b0;
               r_fault        <= 1'b0;
            end
         endcase
      end
   end

   assign repeat_o       = r_repeat;
   assign retry_active_o = r_retry_active;
   assign fault_o        = r_fault;
   assign retry_cnt_o    = r_retry_cnt;
   assign err_count_o    = r_err_count;

endmodule
`default_nettype wire
